uart_apb_regs: RTL and testbench

//  APB3 slave register front-end feeding the UART FIFO block: writes push bytes into its TX FIFO,

---
 rtl/uart_apb_pkg.sv | 23 ++
 rtl/uart_apb_stall_timer.sv | 30 +++
 rtl/uart_apb_regs.sv | 194 +++++++++++++++++++
 tb/tb_uart_apb_regs.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM state type for the UART APB front-end.
package uart_apb_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;

    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_BUSY     = 2;
    localparam int unsigned ST_UART_IRQ = 3;
    localparam int unsigned ST_RXUNDER  = 4;
    localparam int unsigned ST_TXDROP   = 5;

    localparam int unsigned CTRL_RX_IE  = 0;
    localparam int unsigned CTRL_ERR_IE = 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } apb_state_t;

endpackage

// File: rtl/uart_apb_stall_timer.sv
// Wait-state counter for TX-full stalls: clear has priority, counts on enable,
// saturates at STALL_MAX and flags expiry there.
module uart_apb_stall_timer #(
    parameter int unsigned STALL_MAX = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    import uart_apb_pkg::*;

    localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);

    logic [CNT_W-1:0] r_count;

    assign o_expire = (r_count == CNT_W'(STALL_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_apb_regs.sv
// APB3 register front-end for the UART FIFO block: DATA push/pop, STATUS with W1C sticky flags,
// optional CTRL/interrupt enables when UART_APB_IRQ_EN is defined.
module uart_apb_regs #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned STALL_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_PSEL,
    input  logic              S_PENABLE,
    input  logic              S_PWRITE,
    input  logic [ADDR_W-1:0] S_PADDR,
    input  logic [DATA_W-1:0] S_PWDATA,
    output logic [DATA_W-1:0] S_PRDATA,
    output logic              S_PREADY,
    output logic              S_PSLVERR,
    output logic [7:0]        tx_byte,
    output logic              transmit,
    input  logic              tx_fifo_full,
    input  logic [7:0]        rx_byte,
    output logic              rx_fifo_pop,
    input  logic              rx_fifo_empty,
    input  logic              uart_busy,
    input  logic              uart_irq,
    output logic              irq
);
    import uart_apb_pkg::*;

    apb_state_t        r_state;
    apb_state_t        w_state_nxt;
    logic              r_rxunder;
    logic              r_txdrop;
    logic              r_irq;
    logic              w_access;
    logic [2:0]        w_sel;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_ctrl_rd;
    logic              w_timer_en;
    logic              w_timer_clr;
    logic              w_expire;
    logic              w_set_rxunder;
    logic              w_set_txdrop;
    logic              w_status_we;
    logic              w_ctrl_we;
    logic              w_unused;

    // Reset also gates the access qualifier so every combinational output is 0 while rst is high.
    assign w_access = S_PSEL & S_PENABLE & ~rst;
    assign w_sel    = S_PADDR[3:1];
    assign irq      = r_irq;
    assign tx_byte  = transmit ? S_PWDATA[7:0] : '0;

    always_comb begin
        w_status              = '0;
        w_status[ST_RX_EMPTY] = rx_fifo_empty;
        w_status[ST_TX_FULL]  = tx_fifo_full;
        w_status[ST_BUSY]     = uart_busy;
        w_status[ST_UART_IRQ] = uart_irq;
        w_status[ST_RXUNDER]  = r_rxunder;
        w_status[ST_TXDROP]   = r_txdrop;
    end

    uart_apb_stall_timer #(
        .STALL_MAX(STALL_MAX)
    ) u_stall_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_timer_clr),
        .i_enable(w_timer_en),
        .o_expire(w_expire)
    );

    // Clearing whenever the FSM heads to IDLE guarantees a fresh count for back-to-back stalls.
    assign w_timer_clr = (w_state_nxt == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        S_PREADY      = 1'b0;
        S_PSLVERR     = 1'b0;
        S_PRDATA      = '0;
        transmit      = 1'b0;
        rx_fifo_pop   = 1'b0;
        w_timer_en    = 1'b0;
        w_set_rxunder = 1'b0;
        w_set_txdrop  = 1'b0;
        w_status_we   = 1'b0;
        w_ctrl_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (S_PWRITE && (w_sel == REG_DATA)) begin
                        if (tx_fifo_full) begin
                            w_timer_en  = 1'b1;
                            w_state_nxt = S_STALL;
                        end else begin
                            S_PREADY = 1'b1;
                            transmit = 1'b1;
                        end
                    end else begin
                        S_PREADY = 1'b1;
                        if (S_PWRITE) begin
                            w_status_we = (w_sel == REG_STATUS);
                            w_ctrl_we   = (w_sel == REG_CTRL);
                        end else begin
                            case (w_sel)
                                REG_DATA: begin
                                    if (!rx_fifo_empty) begin
                                        S_PRDATA    = {{(DATA_W-8){1'b0}}, rx_byte};
                                        rx_fifo_pop = 1'b1;
                                    end else begin
                                        w_set_rxunder = 1'b1;
                                    end
                                end
                                REG_STATUS: S_PRDATA = w_status;
                                REG_CTRL:   S_PRDATA = w_ctrl_rd;
                                default:    S_PRDATA = '0;
                            endcase
                        end
                    end
                end
            end
            S_STALL: begin
                // A freeing FIFO wins over an expiry landing on the same cycle.
                if (!w_access) begin
                    w_state_nxt = S_IDLE;
                end else if (!tx_fifo_full) begin
                    S_PREADY    = 1'b1;
                    transmit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_expire) begin
                    S_PREADY     = 1'b1;
                    S_PSLVERR    = 1'b1;
                    w_set_txdrop = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxunder <= 1'b0;
            r_txdrop  <= 1'b0;
        end else begin
            r_rxunder <= w_set_rxunder | (r_rxunder & ~(w_status_we & S_PWDATA[ST_RXUNDER]));
            r_txdrop  <= w_set_txdrop  | (r_txdrop  & ~(w_status_we & S_PWDATA[ST_TXDROP]));
        end
    end

`ifdef UART_APB_IRQ_EN
    logic [1:0] r_ctrl;

    assign w_ctrl_rd = {{(DATA_W-2){1'b0}}, r_ctrl};
    assign w_unused  = ^{S_PWDATA[DATA_W-1:8], S_PADDR[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_ctrl_we) begin
                r_ctrl <= S_PWDATA[1:0];
            end
            r_irq <= (r_ctrl[CTRL_RX_IE] & ~rx_fifo_empty)
                   | (r_ctrl[CTRL_ERR_IE] & (r_rxunder | r_txdrop))
                   | (r_ctrl[CTRL_RX_IE] & uart_irq);
        end
    end
`else
    assign w_ctrl_rd = '0;
    assign w_unused  = ^{S_PWDATA[DATA_W-1:8], S_PADDR[0], w_ctrl_we};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= uart_irq;
        end
    end
`endif

endmodule

// File: tb/tb_uart_apb_regs.sv
// Directed self-checking bench for uart_apb_regs: vector table for single-cycle accesses,
// hand sequences for stalls, expiry, W1C, reset abort, PSEL drop and irq.
module tb_uart_apb_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        tx_full;
    logic [7:0]  rx_byte;
    logic        rx_pop;
    logic        rx_empty;
    logic        busy;
    logic        uirq;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] cap_prdata;
    logic        cap_slverr;
    logic [7:0]  cap_txb;
    int          tx_pulses;
    int          pop_pulses;
    logic        setup_bad;

    always #5 clk = ~clk;

    uart_apb_regs #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .STALL_MAX(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .S_PSEL       (psel),
        .S_PENABLE    (penable),
        .S_PWRITE     (pwrite),
        .S_PADDR      (paddr),
        .S_PWDATA     (pwdata),
        .S_PRDATA     (prdata),
        .S_PREADY     (pready),
        .S_PSLVERR    (pslverr),
        .tx_byte      (tx_byte),
        .transmit     (transmit),
        .tx_fifo_full (tx_full),
        .rx_byte      (rx_byte),
        .rx_fifo_pop  (rx_pop),
        .rx_fifo_empty(rx_empty),
        .uart_busy    (busy),
        .uart_irq     (uirq),
        .irq          (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // full_cycles >= 0: tx_full is held high for that many ACCESS cycles, then dropped.
    task automatic apb_xfer(input logic w, input logic [3:0] a, input logic [15:0] d,
                            input int full_cycles, input int maxwait,
                            output int waits, output logic timed_out);
        int k;
        waits = 0; timed_out = 1'b0; tx_pulses = 0; pop_pulses = 0;
        cap_prdata = '0; cap_slverr = 1'b0; cap_txb = '0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        #1;
        setup_bad = pready | transmit | rx_pop;
        @(negedge clk);
        penable = 1'b1;
        k = 0;
        forever begin
            if (full_cycles >= 0) tx_full = (k < full_cycles);
            #1;
            if (transmit) tx_pulses++;
            if (rx_pop) pop_pulses++;
            if (pready) begin
                cap_prdata = prdata; cap_slverr = pslverr; cap_txb = tx_byte;
                break;
            end
            waits++;
            if (waits > maxwait) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        #1;
    endtask

    typedef struct {
        logic        w;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        full;
        logic        empty;
        logic        busy;
        logic [7:0]  rxb;
        logic [15:0] e_prd;
        logic        e_err;
        int          e_tx;
        logic [7:0]  e_txb;
        int          e_pop;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int   waits;
        logic to;

        vecs[0]  = '{1'b1, 4'h0, 16'h0041, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1, 8'h41, 0};
        vecs[1]  = '{1'b1, 4'h0, 16'h12A5, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1, 8'hA5, 0};
        vecs[2]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h7E, 16'h007E, 1'b0, 0, 8'h00, 1};
        vecs[3]  = '{1'b0, 4'h2, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0004, 1'b0, 0, 8'h00, 0};
        vecs[4]  = '{1'b0, 4'h2, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0003, 1'b0, 0, 8'h00, 0};
        vecs[5]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h99, 16'h0000, 1'b0, 0, 8'h00, 0};
        vecs[6]  = '{1'b0, 4'h2, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0010, 1'b0, 0, 8'h00, 0};
        vecs[7]  = '{1'b1, 4'h2, 16'h0010, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 8'h00, 0};
        vecs[8]  = '{1'b0, 4'h2, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 8'h00, 0};
        vecs[9]  = '{1'b0, 4'h6, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h55, 16'h0000, 1'b0, 0, 8'h00, 0};
        vecs[10] = '{1'b1, 4'h8, 16'h0041, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 8'h00, 0};
        vecs[11] = '{1'b0, 4'h4, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 8'h00, 0};
        vecs[12] = '{1'b0, 4'hE, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 8'h00, 0};

        // Reset with an active write on the bus: outputs must stay 0.
        rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'h0; pwdata = 16'h00AA;
        tx_full = 1'b0; rx_empty = 1'b0; rx_byte = 8'h11; busy = 1'b0; uirq = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst pready", pready, 1'b0);
        chk("rst pslverr", pslverr, 1'b0);
        chk("rst prdata", prdata, 16'h0);
        chk("rst transmit", transmit, 1'b0);
        chk("rst tx_byte", tx_byte, 8'h0);
        chk("rst pop", rx_pop, 1'b0);
        chk("rst irq", irq, 1'b0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            tx_full = vecs[i].full; rx_empty = vecs[i].empty; busy = vecs[i].busy; rx_byte = vecs[i].rxb;
            apb_xfer(vecs[i].w, vecs[i].addr, vecs[i].wdata, -1, 20, waits, to);
            chk($sformatf("v%0d setup", i), setup_bad, 1'b0);
            chk($sformatf("v%0d waits", i), waits, 0);
            chk($sformatf("v%0d prdata", i), cap_prdata, vecs[i].e_prd);
            chk($sformatf("v%0d pslverr", i), cap_slverr, vecs[i].e_err);
            chk($sformatf("v%0d tx_pulses", i), tx_pulses, vecs[i].e_tx);
            chk($sformatf("v%0d tx_byte", i), cap_txb, vecs[i].e_txb);
            chk($sformatf("v%0d pops", i), pop_pulses, vecs[i].e_pop);
        end
        rx_empty = 1'b0; busy = 1'b0;

        // Full for 5 ACCESS cycles, push on the 6th.
        apb_xfer(1'b1, 4'h0, 16'h0055, 5, 50, waits, to);
        chk("stall5 timeout", to, 1'b0);
        chk("stall5 waits", waits, 5);
        chk("stall5 pslverr", cap_slverr, 1'b0);
        chk("stall5 tx_pulses", tx_pulses, 1);
        chk("stall5 tx_byte", cap_txb, 8'h55);

        // Full stuck: error after STALL_MAX=8 waits, byte dropped.
        tx_full = 1'b1;
        apb_xfer(1'b1, 4'h0, 16'h0066, -1, 50, waits, to);
        chk("stuck timeout", to, 1'b0);
        chk("stuck waits", waits, 8);
        chk("stuck pslverr", cap_slverr, 1'b1);
        chk("stuck tx_pulses", tx_pulses, 0);
        tx_full = 1'b0;
        apb_xfer(1'b0, 4'h2, 16'h0, -1, 20, waits, to);
        chk("stuck status", cap_prdata, 16'h0020);

        // Back-to-back stall after an expiry must also get a full budget.
        apb_xfer(1'b1, 4'h0, 16'h0077, 7, 50, waits, to);
        chk("restall waits", waits, 7);
        chk("restall tx_pulses", tx_pulses, 1);
        chk("restall pslverr", cap_slverr, 1'b0);

        // Underrun, clear both flags, immediate new underrun: RXUNDER set again, TXDROP gone.
        rx_empty = 1'b1;
        apb_xfer(1'b0, 4'h0, 16'h0, -1, 20, waits, to);
        apb_xfer(1'b1, 4'h2, 16'h0030, -1, 20, waits, to);
        apb_xfer(1'b0, 4'h0, 16'h0, -1, 20, waits, to);
        chk("under pslverr", cap_slverr, 1'b0);
        chk("under prdata", cap_prdata, 16'h0);
        rx_empty = 1'b0;
        apb_xfer(1'b0, 4'h2, 16'h0, -1, 20, waits, to);
        chk("w1c status", cap_prdata, 16'h0010);
        apb_xfer(1'b1, 4'h2, 16'h0010, -1, 20, waits, to);

        // Reset asserted mid-stall.
        tx_full = 1'b1;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 16'h00C3;
        @(negedge clk);
        penable = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("prerst pready", pready, 1'b0);
        #1 rst = 1'b1;
        tx_full = 1'b0;
        #1;
        chk("midrst pready", pready, 1'b0);
        chk("midrst transmit", transmit, 1'b0);
        chk("midrst tx_byte", tx_byte, 8'h0);
        chk("midrst pslverr", pslverr, 1'b0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        rst = 1'b0;
        tx_pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (transmit) tx_pulses++;
        end
        chk("postrst tx_pulses", tx_pulses, 0);

        // PSEL dropped mid-stall: no push, no flags, FSM back to IDLE.
        tx_full = 1'b1;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 16'h00D4;
        @(negedge clk);
        penable = 1'b1;
        repeat (3) @(negedge clk);
        psel = 1'b0; penable = 1'b0; tx_full = 1'b0;
        tx_pulses = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (transmit) tx_pulses++;
            @(negedge clk);
        end
        chk("drop tx_pulses", tx_pulses, 0);
        apb_xfer(1'b0, 4'h2, 16'h0, -1, 20, waits, to);
        chk("drop status", cap_prdata, 16'h0000);
        apb_xfer(1'b1, 4'h0, 16'h0033, -1, 20, waits, to);
        chk("drop next waits", waits, 0);
        chk("drop next tx_byte", cap_txb, 8'h33);

`ifdef UART_APB_IRQ_EN
        rx_empty = 1'b0;
        apb_xfer(1'b1, 4'h4, 16'h0001, -1, 20, waits, to);
        chk("irq before", irq, 1'b0);
        @(posedge clk); #1;
        chk("irq rx_ie", irq, 1'b1);
        apb_xfer(1'b0, 4'h4, 16'h0, -1, 20, waits, to);
        chk("ctrl readback", cap_prdata, 16'h0001);
`else
        @(negedge clk);
        uirq = 1'b1;
        #1;
        chk("irq before", irq, 1'b0);
        @(posedge clk); #1;
        chk("irq follow", irq, 1'b1);
        uirq = 1'b0;
        @(posedge clk); #1;
        chk("irq release", irq, 1'b0);
        apb_xfer(1'b1, 4'h4, 16'h0003, -1, 20, waits, to);
        apb_xfer(1'b0, 4'h4, 16'h0, -1, 20, waits, to);
        chk("ctrl readback", cap_prdata, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
